// File: rtl/vo_pkg.sv
// ----------------------------------------------------------------------------
// vo_pkg
// Shared definitions for the orientation moment unit.
//   vo_n(radius)             : patch size N = 2*radius+1
//   vo_sum_w(pix_w, radius)  : signed moment width wide enough for any window
//   vo_in_circle(radius,r,c) : circular mask membership for row r, column c
//   vo_state_e               : window-fill state (FILL / RUN)
// ----------------------------------------------------------------------------
package vo_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } vo_state_e;

    function automatic int vo_n(input int radius);
        return 2 * radius + 1;
    endfunction

    // Worst case |moment| is N*N*RADIUS*max_pixel; one extra bit for the sign.
    function automatic int vo_sum_w(input int pix_w, input int radius);
        int n;
        n = vo_n(radius);
        return pix_w + $clog2(n * n * radius + 1) + 1;
    endfunction

    function automatic bit vo_in_circle(input int radius, input int r, input int c);
        int dx;
        int dy;
        dx = c - radius;
        dy = r - radius;
        return (dx * dx + dy * dy) <= (radius * radius);
    endfunction

endpackage : vo_pkg

// File: rtl/orientation_col_weight.sv
// ----------------------------------------------------------------------------
// orientation_col_weight
// Combinational weighting of one patch column sitting at window column COL_POS.
// Produces the masked pixel sum (later scaled by the column's x-weight in the
// top level) and the column's y-moment sum((RADIUS-r) * p[r]).
//
// Ports
//   col_i   in   N*PIX_W  column pixels, row r at [r*PIX_W +: PIX_W]
//   psum_o  out  SUM_W    signed masked pixel sum
//   ymom_o  out  SUM_W    signed masked y-moment
// ----------------------------------------------------------------------------
module orientation_col_weight
    import vo_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int RADIUS    = 3,
    parameter bit CIRC_MASK = 1'b0,
    parameter int SUM_W     = vo_sum_w(PIX_W, RADIUS),
    parameter int COL_POS   = 0
) (
    input  logic [(2*RADIUS+1)*PIX_W-1:0] col_i,
    output logic signed [SUM_W-1:0]       psum_o,
    output logic signed [SUM_W-1:0]       ymom_o
);

    localparam int N = vo_n(RADIUS);

    logic signed [SUM_W-1:0] pix_ext [N];

    // Pixels are unsigned: zero-extend before any signed weighting.
    for (genvar r = 0; r < N; r++) begin : g_ext
        assign pix_ext[r] = SUM_W'(col_i[r*PIX_W +: PIX_W]);
    end

    // Mask terms are elaboration-time constants, so masked-out rows vanish.
    always_comb begin
        psum_o = '0;
        ymom_o = '0;
        for (int r = 0; r < N; r++) begin
            if (!CIRC_MASK || vo_in_circle(RADIUS, r, COL_POS)) begin
                psum_o = psum_o + pix_ext[r];
                ymom_o = ymom_o + pix_ext[r] * SUM_W'(RADIUS - r);
            end
        end
    end

endmodule : orientation_col_weight

// File: rtl/orientation_moment_unit.sv
// ----------------------------------------------------------------------------
// orientation_moment_unit
// Streaming intensity-centroid moments over an N x N patch (N = 2*RADIUS+1).
// Columns arrive one per accepted cycle; the window is the last N accepted
// columns of the current line. Every accepted column once the window is full
// yields one registered result:
//   o_mx = sum (c-RADIUS) * p[r][c] * m[r][c]
//   o_my = sum (RADIUS-r) * p[r][c] * m[r][c]
//
// Ports
//   i_clk    in   1        clock, rising edge
//   i_rst    in   1        synchronous active-high reset
//   i_valid  in   1        qualifies i_col / i_sol
//   i_sol    in   1        accepted column starts a new line
//   i_col    in   N*PIX_W  patch column, row r at [r*PIX_W +: PIX_W]
//   o_valid  out  1        one-cycle pulse: o_mx/o_my hold a full window
//   o_mx     out  SUM_W    signed x-moment
//   o_my     out  SUM_W    signed y-moment
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | fewer than N columns accepted on this line; o_valid stays low
// ST_RUN  | window full; every accepted column produces a result
// ----------------------------------------------------------------------------
module orientation_moment_unit
    import vo_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int RADIUS    = 3,
    parameter bit CIRC_MASK = 1'b0,
    parameter int SUM_W     = vo_sum_w(PIX_W, RADIUS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic                          i_sol,
    input  logic [(2*RADIUS+1)*PIX_W-1:0] i_col,
    output logic                          o_valid,
    output logic signed [SUM_W-1:0]       o_mx,
    output logic signed [SUM_W-1:0]       o_my
);

    localparam int N     = vo_n(RADIUS);
    localparam int COL_W = N * PIX_W;
    localparam int CNT_W = $clog2(N + 1);

    // Only the newest N-1 columns need storing: the candidate window is those
    // plus i_col, and the oldest stored column drops out on the same edge.
    logic [COL_W-1:0]        store_q [N-1];
    logic [COL_W-1:0]        win_d   [N];
    logic [CNT_W-1:0]        fill_q;
    vo_state_e               state_q;
    logic                    valid_q;
    logic signed [SUM_W-1:0] mx_q;
    logic signed [SUM_W-1:0] my_q;
    logic signed [SUM_W-1:0] mx_d;
    logic signed [SUM_W-1:0] my_d;
    logic signed [SUM_W-1:0] psum [N];
    logic signed [SUM_W-1:0] ymom [N];

    // Window as it would look if i_col were accepted this cycle. A start of
    // line wipes the older columns so they contribute nothing.
    always_comb begin
        for (int c = 0; c < N - 1; c++) begin
            win_d[c] = i_sol ? '0 : store_q[c];
        end
        win_d[N-1] = i_col;
    end

    for (genvar c = 0; c < N; c++) begin : g_col
        orientation_col_weight #(
            .PIX_W     (PIX_W),
            .RADIUS    (RADIUS),
            .CIRC_MASK (CIRC_MASK),
            .SUM_W     (SUM_W),
            .COL_POS   (c)
        ) u_col_weight (
            .col_i  (win_d[c]),
            .psum_o (psum[c]),
            .ymom_o (ymom[c])
        );
    end

    always_comb begin
        mx_d = '0;
        my_d = '0;
        for (int c = 0; c < N; c++) begin
            mx_d = mx_d + psum[c] * SUM_W'(c - RADIUS);
            my_d = my_d + ymom[c];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            valid_q <= 1'b0;
            mx_q    <= '0;
            my_q    <= '0;
            for (int c = 0; c < N - 1; c++) begin
                store_q[c] <= '0;
            end
        end else if (i_valid) begin
            for (int c = 0; c < N - 1; c++) begin
                store_q[c] <= win_d[c+1];
            end
            mx_q <= mx_d;
            my_q <= my_d;
            if (i_sol) begin
                state_q <= ST_FILL;
                fill_q  <= CNT_W'(1);
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_FILL: begin
                        fill_q <= fill_q + CNT_W'(1);
                        if (fill_q == CNT_W'(N - 1)) begin
                            state_q <= ST_RUN;
                            valid_q <= 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // fill_q stays saturated at N
                        valid_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_FILL;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_mx    = mx_q;
    assign o_my    = my_q;

endmodule : orientation_moment_unit

// File: doc/orientation_moment_unit.md
ORIENTATION_MOMENT_UNIT -- requirements
Module: orientation_moment_unit

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning the unsigned pixel width.
REQ-002 The block SHALL have parameter RADIUS, default 3, range 1..7, meaning the patch half-size; N = 2*RADIUS+1.
REQ-003 The block SHALL have parameter CIRC_MASK, default 0, where 0 selects a square NxN patch and 1 selects a circular patch.
REQ-004 The block SHALL have parameter SUM_W, default PIX_W + $clog2(N*N*RADIUS+1) + 1, meaning the signed moment width.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port: i_clk  input  1  clock; all logic on the rising edge.
REQ-007 Port: i_rst  input  1  synchronous active-high reset.
REQ-008 Port: i_valid  input  1  qualifies i_col and i_sol for one column.
REQ-009 Port: i_sol  input  1  start of line; the qualified column is the first column of a new line.
REQ-010 Port: i_col  input  N*PIX_W  one patch column, top to bottom; row r occupies bits [r*PIX_W +: PIX_W].
REQ-011 Port: o_valid  output  1  o_mx/o_my hold the moments of a complete window.
REQ-012 Port: o_mx  output  SUM_W  signed x-moment.
REQ-013 Port: o_my  output  SUM_W  signed y-moment.

Function
REQ-014 The block SHALL treat only i_valid=1 cycles as accepted columns; with i_valid=0, all state and outputs SHALL hold, except that o_valid SHALL drop to 0.
REQ-015 The window SHALL be the last N accepted columns of the current line; column index c runs 0 (oldest) to N-1 (newest), and row index r runs 0 (top) to N-1.
REQ-016 The block SHALL compute o_mx = sum over the window of (c-RADIUS)*p[r][c]*m[r][c] and o_my = sum of (RADIUS-r)*p[r][c]*m[r][c].
REQ-017 The mask m SHALL be 1 everywhere when CIRC_MASK=0; when CIRC_MASK=1, m SHALL be 1 iff (c-RADIUS)^2+(r-RADIUS)^2 <= RADIUS^2.
REQ-018 All arithmetic SHALL be exact at SUM_W bits, with no saturation or truncation, and pixels zero-extended before weighting.
REQ-019 A fill counter SHALL count accepted columns of the current line, saturating at N.
REQ-020 When an accepted column has i_sol=1, the fill count SHALL become 1, that column SHALL become the sole window member, and contributions from earlier columns SHALL be discarded.
REQ-021 The block SHALL ignore i_sol when i_valid=0.
REQ-022 Latency: when the column accepted at edge k makes the fill count N, o_valid SHALL be 1 after edge k, with o_mx/o_my reflecting that window.
REQ-023 o_valid SHALL pulse exactly once per accepted column while the fill count is N, giving one result per column step.
REQ-024 o_valid SHALL be 0 after any accepted column that leaves the fill count below N.
REQ-025 The states SHALL be FILL (count<N, o_valid low) and RUN (count=N); i_sol or reset SHALL return the block to FILL.

Reset
REQ-026 When i_rst=1 at a clock edge, the fill count, every internal accumulator or column store, o_valid, o_mx and o_my SHALL all become 0.
REQ-027 Reset SHALL take priority over i_valid/i_sol in the same cycle; a column presented with reset asserted SHALL be dropped.
REQ-028 Reset asserted mid-window SHALL discard the partial window; after release, N new accepted columns SHALL be required before o_valid.

Structure
REQ-029 N, SUM_W and a constant function for the circular mask SHALL reside in the shared package vo_pkg.
REQ-030 One sub-module, orientation_col_weight, SHALL compute a column's masked pixel sum and y-moment for a given column position.
REQ-031 Outputs SHALL be driven directly from registers.

Verification (RADIUS=3, PIX_W=8 unless noted)
REQ-032 Seven columns, all pixels 255, square mode -> o_valid after the 7th accepted column; mx=0, my=0.
REQ-033 Column 0 has only row 0 = 100 and the other six columns are zero -> mx=-300, my=+300; on the next accepted zero column -> mx=0, my=0.
REQ-034 Column k all pixels = k (k=0..6) -> mx=196, my=0; the same stream with random i_valid gaps -> identical values, with o_valid only on the cycle after the 7th accepted column.
REQ-035 i_sol on the 5th accepted column of a line -> o_valid stays low for the next 6 accepted columns and rises after the 7th; i_rst pulsed mid-window -> all outputs 0 and a full refill is required.
REQ-036 CIRC_MASK=1: row 0 = 100 in column 0 only -> mx=0, my=0; row 0 = 100 in column 3 only -> mx=0, my=300.
